shift_sequencer: RTL

Multi-cycle controller for the core's shift/MOV datapath. Accepts one shift request per valid/ready handshake, captures operands and incoming flags, iterates the shift over `STEP` bits per cycle under an FSM, and returns the result with updated N/Z/C. It sits between the decode/issue stage and the register-file write port. It replaces level-triggered shifting with a clocked, back-pressurable sequence.

---
 rtl/shift_pkg.sv | 19 +
 rtl/shift_step.sv | 46 ++++
 rtl/shift_sequencer.sv | 129 ++++++++++++
 3 files changed

// File: rtl/shift_pkg.sv
// Shared definitions for the shift/MOV sequencer: shift-type encodings,
// the sequencer FSM state type and the shift-count cap.
package shift_pkg;

    localparam logic [1:0] ST_LSL = 2'b00;
    localparam logic [1:0] ST_LSR = 2'b01;
    localparam logic [1:0] ST_ASR = 2'b10;
    localparam logic [1:0] ST_ROR = 2'b11;

    // One past a full word: enough for LSL/LSR to clear C and ASR to saturate.
    localparam int SHIFT_CAP = 33;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        SHIFT = 2'd1,
        DONE  = 2'd2
    } state_t;

endpackage

// File: rtl/shift_step.sv
// One iteration of the shift datapath: shifts a word by k (1..8) bits and
// returns the last bit shifted out; k == 0 passes value and carry through.
module shift_step
    import shift_pkg::*;
(
    input  logic [31:0] value,
    input  logic        carry_in,
    input  logic [3:0]  k,
    input  logic [1:0]  stype,
    output logic [31:0] result,
    output logic        carry_out
);

    logic [39:0] wide;

    always_comb begin
        wide      = '0;
        result    = value;
        carry_out = carry_in;
        if (k != 4'd0) begin
            // Eight guard bits beside the word catch the last bit shifted out.
            case (stype)
                ST_LSL: begin
                    wide      = {8'b0, value} << k;
                    result    = wide[31:0];
                    carry_out = wide[32];
                end
                ST_LSR: begin
                    wide      = {value, 8'b0} >> k;
                    result    = wide[39:8];
                    carry_out = wide[7];
                end
                ST_ASR: begin
                    wide      = $signed({value, 8'b0}) >>> k;
                    result    = wide[39:8];
                    carry_out = wide[7];
                end
                default: begin
                    result    = (value >> k) | (value << (6'd32 - {2'b0, k}));
                    carry_out = result[31];
                end
            endcase
        end
    end

endmodule

// File: rtl/shift_sequencer.sv
// Clocked, back-pressurable shift/MOV sequencer between issue and register write.
// Build option SHIFT_SEQ_ROR_EN: stype 11 rotates; otherwise it is a MOV pass-through.
module shift_sequencer
    import shift_pkg::*;
#(
    parameter int STEP = 1
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        flush,
    input  logic        req_valid,
    output logic        req_ready,
    input  logic [31:0] req_rm,
    input  logic [7:0]  req_amount,
    input  logic [1:0]  req_stype,
    input  logic        req_s,
    input  logic        req_carry,
    input  logic        req_zero,
    input  logic        req_neg,
    output logic        rsp_valid,
    input  logic        rsp_ready,
    output logic [31:0] rsp_rd,
    output logic        rsp_carry,
    output logic        rsp_zero,
    output logic        rsp_neg,
    output state_t      state_dbg
);

    // Handshakes: a transfer happens on a rising edge where valid and ready are
    // both high; req_ready is high only in IDLE, rsp_valid only in DONE.

    state_t      state, state_next;
    logic [31:0] work;
    logic [5:0]  count;
    logic [1:0]  stype_q;
    logic        s_q, c_in_q, z_in_q, n_in_q;
    logic        last_c;
    logic        use_cin;

    logic [5:0]  accept_count;
    logic        accept_use_cin;
    logic        accept_last_c;
    logic [3:0]  k;
    logic [31:0] step_result;
    logic        step_carry;

    always_comb begin
        accept_count   = (req_amount > 8'(SHIFT_CAP)) ? 6'(SHIFT_CAP) : req_amount[5:0];
        accept_use_cin = (req_amount == 8'd0);
        accept_last_c  = req_carry;
        if (req_stype == ST_ROR) begin
`ifdef SHIFT_SEQ_ROR_EN
            // A multiple-of-32 rotate leaves rm intact but still reports rm[31] as C.
            accept_count  = {1'b0, req_amount[4:0]};
            accept_last_c = req_rm[31];
`else
            accept_count   = 6'd0;
            accept_use_cin = 1'b1;
`endif
        end
    end

    always_comb begin
        k = (count > 6'(STEP)) ? 4'(STEP) : count[3:0];
    end

    shift_step u_step (
        .value     (work),
        .carry_in  (last_c),
        .k         (k),
        .stype     (stype_q),
        .result    (step_result),
        .carry_out (step_carry)
    );

    always_comb begin
        state_next = state;
        case (state)
            IDLE:    if (req_valid) state_next = (accept_count == 6'd0) ? DONE : SHIFT;
            SHIFT:   if (count == {2'b0, k}) state_next = DONE;
            DONE:    if (rsp_ready) state_next = IDLE;
            default: state_next = IDLE;
        endcase
        if (flush) state_next = IDLE;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state   <= IDLE;
            work    <= '0;
            count   <= '0;
            stype_q <= '0;
            s_q     <= 1'b0;
            c_in_q  <= 1'b0;
            z_in_q  <= 1'b0;
            n_in_q  <= 1'b0;
            last_c  <= 1'b0;
            use_cin <= 1'b0;
        end else begin
            state <= state_next;
            if (!flush && state == IDLE && req_valid) begin
                work    <= req_rm;
                count   <= accept_count;
                stype_q <= req_stype;
                s_q     <= req_s;
                c_in_q  <= req_carry;
                z_in_q  <= req_zero;
                n_in_q  <= req_neg;
                last_c  <= accept_last_c;
                use_cin <= accept_use_cin;
            end else if (!flush && state == SHIFT) begin
                work   <= step_result;
                last_c <= step_carry;
                count  <= count - {2'b0, k};
            end
        end
    end

    always_comb begin
        req_ready = (state == IDLE);
        rsp_valid = (state == DONE);
        rsp_rd    = work;
        rsp_carry = (s_q && !use_cin) ? last_c : c_in_q;
        rsp_zero  = s_q ? (work == 32'd0) : z_in_q;
        rsp_neg   = s_q ? work[31] : n_in_q;
        state_dbg = state;
    end

endmodule
